simple_st0_st_float2fix: RTL and testbench
==========================================

// Module: simple_st0_st_float2fix
// PURPOSE
//  Converts a float_24_8 stream to signed fixed point. It is the inverse of the
//  fixed-to-float normalise/round path in the adder stages.
//  Feeds fixed-point consumers (accumulators, DMA out) from float datapath results.
//  Two-stage pipeline with valid/ready handshake, full throughput, stall-safe.
// PARAMETERS
//  WIDTH  32   output fixed-point width, two's complement
//  FRAC   16   fractional bits of output (LSB weight 2^-FRAC)
//  BIAS   127  float exponent bias
// PORTS
//  clk        input   1      clock, rising edge
//  reset      input   1      asynchronous, active-low reset (0 = in reset)
//  in_data    input   32     float_24_8 operand {sgn, exp[7:0], man[22:0]}
//  in_valid   input   1      in_data valid
//  in_ready   output  1      block accepts in_data this cycle
//  out_data   output  WIDTH  signed fixed-point result
//  out_sat    output  1      result was clipped (qualifies out_data)
//  out_valid  output  1      out_data/out_sat valid
//  out_ready  input   1      consumer accepts this cycle
//  sat_count  output  16     saturation event count (FLOAT2FIX_SAT_CNT_EN only)
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid=0, out_data=0, out_sat=0,
//    sat_count=0, internal stage valids=0.
//    in_ready=1 one cycle after release.
//  - Transfer occurs on valid&ready at the rising edge.
//  - Latency: 2 cycles from input transfer to out_valid when not stalled.
//  - Stage1 regs: sgn, {1,man} (24b), signed shift s = exp - BIAS + FRAC - 23 (10b),
//    zero flag (exp < 10, matching the adder flush rule), ovf flag (exp==255).
//  - Stage2 regs: out_data, out_sat. Stage2 computes from the stage1 fields:
//    - s >= 0: mag = {1,man} << s. ovf when any bit beyond WIDTH-1 is set,
//      or when s >= WIDTH.
//    - s < 0: mag = {1,man} >> -s, round half-to-even using guard/sticky bits.
//      -s > 25 gives mag = 0.
//    - Result = sgn ? -mag : mag.
//    - Positive saturates to 2^(WIDTH-1)-1 when mag > 2^(WIDTH-1)-1.
//    - Negative saturates to -2^(WIDTH-1) when mag > 2^(WIDTH-1).
//    - out_sat=1 when saturated or exp==255.
//    - exp==255 saturates by sign; NaN/Inf are not distinguished.
//    - zero flag forces 0 with out_sat=0. Both +0 and -0 give 0.
//  - Flow: each stage holds its contents while the next stage is full and not draining.
//    - s2 advances when !out_valid | out_ready.
//    - s1 advances when !s1_valid | s2 advances.
//    - in_ready = !s1_valid | s2 advances (combinational path from out_ready).
//  - out_data/out_sat stay stable while out_valid & !out_ready. No drop, no duplication.
//  - Simultaneous input and output transfers in one cycle: both take effect and
//    occupancy is unchanged.
//  - Reset mid-stream: in-flight data is discarded. No output transfer until new input.
// CONFIGURATION
//  FLOAT2FIX_SAT_CNT_EN defined:
//    - sat_count increments on each output transfer with out_sat=1.
//    - It holds at 16'hFFFF (no wrap) and clears only on reset.
//  FLOAT2FIX_SAT_CNT_EN undefined: sat_count port is present and tied to 16'd0.
//    No counter logic is built.
// TESTING  (WIDTH=32, FRAC=16, BIAS=127)
//  - Basic values:
//    - 1.0 {0,127,0} -> 32'h00010000, sat=0, out_valid 2 cycles after accept.
//    - -2.5 {1,128,23'h200000} -> 32'hFFFD8000.
//  - Rounding:
//    - 2^-17 {0,110,0} -> 0 (tie to even).
//    - 1.5*2^-16 {0,111,23'h400000} -> 2.
//    - exp=9 -> 0.
//  - Saturation:
//    - 2^23 {0,150,0} -> 32'h7FFFFFFF, sat=1.
//    - {1,150,0} -> 32'h80000000, sat=1.
//    - {1,142,0} (-2^15) -> 32'h80000000, sat=0.
//    - exp=255 -> clipped by sign, sat=1.
//    - sat_count=3 after these (macro on), 0 (macro off).
//  - Backpressure: 4 back-to-back inputs with out_ready=0 for 5 cycles.
//    -> in_ready drops after 2 accepted, out_data held, all 4 outputs delivered in order.
//  - Throughput: random valid/ready streams of 1000 words.
//    -> output matches reference model, full rate when out_ready=1.
//  - Reset: assert reset with 2 words in flight.
//    -> out_valid=0 immediately, no stale output after release.

Source files
------------

// File: rtl/simple_st0_st_float2fix.sv
// float_24_8 to signed fixed-point converter, two-stage valid/ready pipeline.
// Define FLOAT2FIX_SAT_CNT_EN to build the saturating sat_count event counter.
module simple_st0_st_float2fix #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned FRAC  = 16,
   parameter int unsigned BIAS  = 127
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      sat_count
);
   localparam int unsigned      LP_EW   = WIDTH + 26;
   localparam logic [LP_EW-1:0] LP_MAXP = (LP_EW'(1) << (WIDTH - 1)) - LP_EW'(1);
   localparam logic [LP_EW-1:0] LP_MAXN = LP_EW'(1) << (WIDTH - 1);
   localparam logic [WIDTH-1:0] LP_POS  = {1'b0, {(WIDTH - 1){1'b1}}};
   localparam logic [WIDTH-1:0] LP_NEG  = {1'b1, {(WIDTH - 1){1'b0}}};

   logic             r_rdy_en;
   logic             r_s1_valid;
   logic             r_s1_sgn;
   logic [23:0]      r_s1_man;
   logic [9:0]       r_s1_shift;
   logic             r_s1_zero;
   logic             r_s1_ovf;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic             r_out_sat;

   logic             w_s2_adv;
   logic             w_s1_adv;
   logic             w_in_fire;
   logic [9:0]       w_shift;
   logic [9:0]       w_rsh;
   logic [4:0]       w_rsh_cl;
   logic [49:0]      w_ext;
   logic             w_rnd;
   logic             w_big;
   logic [LP_EW-1:0] w_mag;
   logic             w_clip;
   logic [WIDTH-1:0] w_res;
   logic             w_res_sat;

   assign w_s2_adv  = !r_out_valid | out_ready;
   assign w_s1_adv  = !r_s1_valid | w_s2_adv;
   // in_ready stays low until the first clock after reset release
   assign in_ready  = r_rdy_en & w_s1_adv;
   assign w_in_fire = in_valid & in_ready;
   assign w_shift   = {2'b00, in_data[30:23]} + 10'(FRAC) - 10'(BIAS) - 10'd23;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rdy_en   <= 1'b0;
         r_s1_valid <= 1'b0;
         r_s1_sgn   <= 1'b0;
         r_s1_man   <= '0;
         r_s1_shift <= '0;
         r_s1_zero  <= 1'b0;
         r_s1_ovf   <= 1'b0;
      end else begin
         r_rdy_en <= 1'b1;
         if (w_s1_adv) begin
            r_s1_valid <= w_in_fire;
         end
         if (w_in_fire) begin
            r_s1_sgn   <= in_data[31];
            r_s1_man   <= {1'b1, in_data[22:0]};
            r_s1_shift <= w_shift;
            r_s1_zero  <= (in_data[30:23] < 8'd10);
            r_s1_ovf   <= (in_data[30:23] == 8'hFF);
         end
      end
   end

   always_comb begin
      w_rsh     = 10'd0 - r_s1_shift;
      w_rsh_cl  = (w_rsh > 10'd26) ? 5'd26 : w_rsh[4:0];
      // integer part in [49:26], guard at 25, sticky below; shifts past 26 round to zero anyway
      w_ext     = {r_s1_man, 26'd0} >> w_rsh_cl;
      w_rnd     = w_ext[25] & ((|w_ext[24:0]) | w_ext[26]);
      w_big     = !r_s1_shift[9] && (r_s1_shift >= 10'(WIDTH));
      w_mag     = LP_EW'(r_s1_man) << r_s1_shift;
      if (r_s1_shift[9]) begin
         w_mag = LP_EW'(w_ext[49:26]) + LP_EW'(w_rnd);
      end
      w_clip    = r_s1_ovf | w_big | (r_s1_sgn ? (w_mag > LP_MAXN) : (w_mag > LP_MAXP));
      w_res     = r_s1_sgn ? -w_mag[WIDTH-1:0] : w_mag[WIDTH-1:0];
      w_res_sat = 1'b0;
      if (r_s1_zero) begin
         w_res = '0;
      end else if (w_clip) begin
         w_res     = r_s1_sgn ? LP_NEG : LP_POS;
         w_res_sat = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sat   <= 1'b0;
      end else if (w_s2_adv) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out_data <= w_res;
            r_out_sat  <= w_res_sat;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sat   = r_out_sat;

`ifdef FLOAT2FIX_SAT_CNT_EN
   logic [15:0] r_sat_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sat_cnt <= '0;
      end else if (r_out_valid && out_ready && r_out_sat && (r_sat_cnt != '1)) begin
         r_sat_cnt <= r_sat_cnt + 16'd1;
      end
   end

   assign sat_count = r_sat_cnt;
`else
   assign sat_count = '0;
`endif

endmodule

// File: tb/tb_simple_st0_st_float2fix.sv
// Directed and random-stream checks for simple_st0_st_float2fix (WIDTH=32, FRAC=16, BIAS=127).
module tb_simple_st0_st_float2fix;
   logic        clk;
   logic        reset;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_sat;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sat_count;

   int n_checks = 0;
   int n_errors = 0;
   int exp_sat_cnt = 0;

   simple_st0_st_float2fix #(.WIDTH(32), .FRAC(16), .BIAS(127)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sat_count (sat_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: exact value m*2^sh, rounded half-to-even via remainder, then clipped
   function automatic void model(input logic [31:0] f, output logic [31:0] d, output logic s);
      int     e, sh, n;
      longint m, v, q, rem, half;
      e = int'(f[30:23]);
      m = longint'({1'b1, f[22:0]});
      d = '0;
      s = 1'b0;
      if (e < 10) return;
      if (e == 255) begin
         s = 1'b1;
         d = f[31] ? 32'h80000000 : 32'h7FFFFFFF;
         return;
      end
      sh = e - 127 + 16 - 23;
      if (sh > 30) v = 64'h1_0000_0000;
      else if (sh >= 0) v = m << sh;
      else begin
         n = -sh;
         if (n >= 40) v = 0;
         else begin
            q    = m >> n;
            rem  = m - (q << n);
            half = longint'(1) << (n - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            v = q;
         end
      end
      if (!f[31]) begin
         if (v > 64'd2147483647) begin s = 1'b1; d = 32'h7FFFFFFF; end
         else d = v[31:0];
      end else begin
         if (v > 64'd2147483648) begin s = 1'b1; d = 32'h80000000; end
         else d = 32'(-v);
      end
   endfunction

   function automatic logic [31:0] rand_float();
      logic [7:0]  e;
      logic [22:0] m;
      int          mode;
      mode = $urandom_range(0, 9);
      m    = 23'($urandom);
      if (mode == 0) e = 8'($urandom);
      else if (mode == 1) e = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(250, 255));
      else e = 8'($urandom_range(100, 160));
      if ($urandom_range(0, 3) == 0) m = m & 23'h7FF000;
      return {1'($urandom), e, m};
   endfunction

   task automatic send_and_check(input string tag, input logic [31:0] f,
                                 input logic [31:0] exp_d, input logic exp_s);
      int n, lat;
      in_data   = f;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_accept"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_lat"}, lat, 2);
      check({tag, "_data"}, out_data, exp_d);
      check({tag, "_sat"}, out_sat, exp_s);
      if (exp_s) exp_sat_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic run_stream(input int n, input int p_in, input int p_out,
                             output int cycles, output int in_stalls);
      logic [31:0] q_d[$];
      logic        q_s[$];
      int          sent, got;
      logic        hold, held_pending;
      logic [31:0] ed, held_d;
      logic        es;
      sent = 0; got = 0; cycles = 0; in_stalls = 0; hold = 1'b0; held_pending = 1'b0; held_d = '0;
      while (got < n && cycles < 20 * n + 100) begin
         @(posedge clk); #1;
         if (!hold) begin
            in_valid = (sent < n) && ($urandom_range(0, 99) < p_in);
            if (in_valid) in_data = rand_float();
         end
         out_ready = ($urandom_range(0, 99) < p_out);
         @(negedge clk);
         cycles++;
         if (held_pending) begin
            check("stream_hold_valid", out_valid, 1);
            check("stream_hold_data", out_data, held_d);
         end
         held_pending = out_valid && !out_ready;
         held_d       = out_data;
         hold         = in_valid && !in_ready;
         if (hold) in_stalls++;
         if (in_valid && in_ready) begin
            model(in_data, ed, es);
            q_d.push_back(ed);
            q_s.push_back(es);
            sent++;
         end
         if (out_valid && out_ready) begin
            check("stream_nonempty", q_d.size() != 0, 1);
            if (q_d.size() != 0) begin
               ed = q_d.pop_front();
               es = q_s.pop_front();
               check("stream_data", out_data, ed);
               check("stream_sat", out_sat, es);
               if (es) exp_sat_cnt++;
            end
            got++;
         end
      end
      check("stream_done", got, n);
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   logic [31:0] bp_in [4];
   logic [31:0] bp_exp[4];
   int          idx, got, cyc, st, vcount;

   initial begin
      reset = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_sat", out_sat, 0);
      check("rst_sat_count", sat_count, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", in_ready, 1);

      send_and_check("one",      32'h3F800000, 32'h00010000, 1'b0);
      send_and_check("m2p5",     32'hC0200000, 32'hFFFD8000, 1'b0);
      send_and_check("tie_even", 32'h37000000, 32'h00000000, 1'b0);
      send_and_check("round_up", 32'h37C00000, 32'h00000002, 1'b0);
      send_and_check("exp9",     32'h04800000, 32'h00000000, 1'b0);
      send_and_check("neg_zero", 32'h80000000, 32'h00000000, 1'b0);
      send_and_check("sat_pos",  32'h4B000000, 32'h7FFFFFFF, 1'b1);
      send_and_check("sat_neg",  32'hCB000000, 32'h80000000, 1'b1);
      send_and_check("min_neg",  32'hC7000000, 32'h80000000, 1'b0);
      send_and_check("exp255",   32'h7F800000, 32'h7FFFFFFF, 1'b1);
`ifdef FLOAT2FIX_SAT_CNT_EN
      check("sat_count_dir", sat_count, 3);
`else
      check("sat_count_dir", sat_count, 0);
`endif

      // Backpressure: out_ready low for the first 5 cycles
      bp_in  = '{32'h3F800000, 32'hC0200000, 32'h40400000, 32'h3F000000};
      bp_exp = '{32'h00010000, 32'hFFFD8000, 32'h00030000, 32'h00008000};
      idx = 0; got = 0; cyc = 0;
      while (got < 4 && cyc < 60) begin
         @(posedge clk); #1;
         out_ready = (cyc >= 5);
         in_valid  = (idx < 4);
         if (idx < 4) in_data = bp_in[idx];
         @(negedge clk);
         if (cyc >= 2 && cyc <= 4) begin
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_data", out_data, bp_exp[0]);
         end
         if (cyc == 4) begin
            check("bp_accepted", idx, 2);
            check("bp_in_ready", in_ready, 0);
         end
         if (in_valid && in_ready) idx++;
         if (out_valid && out_ready) begin
            check("bp_out_data", out_data, bp_exp[got]);
            got++;
         end
         cyc++;
      end
      check("bp_all_out", got, 4);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;

      run_stream(20, 100, 100, cyc, st);
      check("full_rate_cycles", cyc, 22);
      check("full_rate_stalls", st, 0);
      run_stream(1000, 70, 60, cyc, st);
`ifdef FLOAT2FIX_SAT_CNT_EN
      check("sat_count_stream", sat_count, (exp_sat_cnt > 65535) ? 65535 : exp_sat_cnt);
`else
      check("sat_count_stream", sat_count, 0);
`endif

      // Reset with two words in flight
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h3F800000;
      @(posedge clk); #1;
      in_data = 32'hC0200000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("mid_pre_valid", out_valid, 1);
      #2 reset = 1'b0;
      #1;
      check("mid_out_valid", out_valid, 0);
      check("mid_out_data", out_data, 0);
      check("mid_out_sat", out_sat, 0);
      check("mid_sat_count", sat_count, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("mid_in_ready", in_ready, 1);
      out_ready = 1'b1;
      vcount = 0;
      repeat (5) begin
         @(negedge clk);
         if (out_valid) vcount++;
      end
      check("mid_no_stale", vcount, 0);
      @(posedge clk); #1;
      send_and_check("post_rst", 32'h3F800000, 32'h00010000, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
